// File: rtl/ctrl_microondas_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_microondas_pkg: scheduler state encoding and power-to-duty mapping.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ctrl_microondas_pkg;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_IDLE = 3'd0;
  localparam sched_state_t ST_HEAT = 3'd1;
  localparam sched_state_t ST_HOLD = 3'd2;
  localparam sched_state_t ST_BEEP = 3'd3;

  localparam int ON_SECS_LOW = 3;
  localparam int ON_SECS_MED = 6;

  // The top power level keeps the magnetron on for the whole window.
  function automatic int on_secs_for(input logic [1:0] pot, input int window_s);
    case (pot)
      2'd0:    return 0;
      2'd1:    return ON_SECS_LOW;
      2'd2:    return ON_SECS_MED;
      default: return window_s;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/magnetron_sched_tick_gen.sv
// ----------------------------------------------------------------------------
// magnetron_sched_tick_gen: half-second / one-second tick prescaler.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module magnetron_sched_tick_gen #(
  parameter int HALF_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick_half,
  output logic tick_sec
);

  localparam int PRE_W = $clog2(HALF_CYCLES + 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             second_half;

  assign tick_half = en & (pre_cnt == PRE_W'(HALF_CYCLES - 1));
  assign tick_sec  = tick_half & second_half;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_cnt     <= '0;
      second_half <= 1'b0;
    end else if (clr) begin
      pre_cnt     <= '0;
      second_half <= 1'b0;
    end else if (en) begin
      pre_cnt <= tick_half ? '0 : pre_cnt + 1'b1;
      if (tick_half) begin
        second_half <= ~second_half;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/magnetron_sched.sv
// ----------------------------------------------------------------------------
// magnetron_sched: magnetron duty slicing, turntable, lamp, fan run-on, buzzer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module magnetron_sched
  import ctrl_microondas_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int WINDOW_S    = 10,
  parameter int FAN_RUNON_S = 5,
  parameter int BEEP_COUNT  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cooking,
  input  logic       paused,
  input  logic       porta,
  input  logic [1:0] potencia,
  input  logic       done,
  output logic       magnetron,
  output logic       turntable,
  output logic       lamp,
  output logic       fan,
  output logic       buzzer,
  output logic [2:0] sched_state
);

  localparam int WIN_W  = $clog2(WINDOW_S + 1);
  localparam int RUN_W  = $clog2(FAN_RUNON_S + 1);
  localparam int BEEP_W = $clog2(2 * BEEP_COUNT + 1);

  sched_state_t      state;
  sched_state_t      state_nxt;
  logic [WIN_W-1:0]  win_cnt;
  logic [WIN_W-1:0]  on_secs;
  logic [RUN_W-1:0]  runon_cnt;
  logic [BEEP_W-1:0] beep_cnt;
  logic              cooking_d;
  logic              cook_rise;
  logic              tick_half;
  logic              tick_sec;
  logic              pre_en;
  logic              pre_clr;
  logic              win_clr;
  logic              beep_clr;
  logic              runon_load;
  logic              runon_clr;

  assign cook_rise = cooking & ~cooking_d;
  assign pre_en    = (state == ST_HEAT) | (state == ST_BEEP) | (runon_cnt != '0);

  magnetron_sched_tick_gen #(
    .HALF_CYCLES (CLK_HZ / 2)
  ) u_tick_gen (
    .clock     (clock),
    .reset     (reset),
    .en        (pre_en),
    .clr       (pre_clr),
    .tick_half (tick_half),
    .tick_sec  (tick_sec)
  );

  // done outranks every other request so a finished cook always beeps.
  always_comb begin
    state_nxt  = state;
    pre_clr    = 1'b0;
    win_clr    = 1'b0;
    beep_clr   = 1'b0;
    runon_load = 1'b0;
    runon_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (done) begin
          state_nxt = ST_BEEP;
          pre_clr   = 1'b1;
          beep_clr  = 1'b1;
        end else if (cooking & ~porta) begin
          state_nxt = ST_HEAT;
          pre_clr   = 1'b1;
          win_clr   = 1'b1;
          runon_clr = 1'b1;
        end
      end
      ST_HEAT, ST_HOLD: begin
        if (done) begin
          state_nxt  = ST_BEEP;
          pre_clr    = 1'b1;
          beep_clr   = 1'b1;
          runon_load = 1'b1;
        end else if (~cooking) begin
          state_nxt  = ST_IDLE;
          runon_load = 1'b1;
        end else if ((state == ST_HEAT) && (porta | paused)) begin
          state_nxt = ST_HOLD;
        end else if ((state == ST_HOLD) && ~paused && ~porta) begin
          state_nxt = ST_HEAT;
        end
      end
      ST_BEEP: begin
        if (cook_rise & ~porta) begin
          state_nxt = ST_HEAT;
          pre_clr   = 1'b1;
          win_clr   = 1'b1;
          runon_clr = 1'b1;
        end else if (tick_half && (beep_cnt == BEEP_W'(2 * BEEP_COUNT - 1))) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      win_cnt   <= '0;
      runon_cnt <= '0;
      beep_cnt  <= '0;
      cooking_d <= 1'b0;
    end else begin
      state     <= state_nxt;
      cooking_d <= cooking;

      if (win_clr) begin
        win_cnt <= '0;
      end else if ((state == ST_HEAT) && tick_sec) begin
        win_cnt <= (win_cnt == WIN_W'(WINDOW_S - 1)) ? '0 : win_cnt + 1'b1;
      end

      if (runon_load) begin
        runon_cnt <= RUN_W'(FAN_RUNON_S);
      end else if (runon_clr) begin
        runon_cnt <= '0;
      end else if (tick_sec && (runon_cnt != '0)) begin
        runon_cnt <= runon_cnt - 1'b1;
      end

      if (beep_clr) begin
        beep_cnt <= '0;
      end else if ((state == ST_BEEP) && tick_half) begin
        beep_cnt <= beep_cnt + 1'b1;
      end
    end
  end

  // Door gating stays combinational so an opened door cuts RF immediately.
  assign on_secs     = WIN_W'(on_secs_for(potencia, WINDOW_S));
  assign magnetron   = (state == ST_HEAT) & (win_cnt < on_secs) & ~porta;
  assign turntable   = (state == ST_HEAT);
  assign lamp        = porta | (state == ST_HEAT) | (state == ST_HOLD);
  assign fan         = (state == ST_HEAT) | (state == ST_HOLD) | (runon_cnt != '0);
  assign buzzer      = (state == ST_BEEP) & ~beep_cnt[0];
  assign sched_state = state;

endmodule

`default_nettype wire

// File: tb/tb_magnetron_sched.sv
// ----------------------------------------------------------------------------
// tb_magnetron_sched: vector table, reset sequence and random run vs. model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_magnetron_sched;

  localparam int CLK_HZ      = 20;
  localparam int WINDOW_S    = 10;
  localparam int FAN_RUNON_S = 5;
  localparam int BEEP_COUNT  = 3;
  localparam int HALF        = CLK_HZ / 2;
  localparam int SEC         = CLK_HZ;
  localparam int BEEP_LEN    = 2 * BEEP_COUNT * HALF;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cooking = 1'b0;
  logic       paused = 1'b0;
  logic       porta = 1'b0;
  logic [1:0] potencia = 2'd0;
  logic       done = 1'b0;
  logic       magnetron, turntable, lamp, fan, buzzer;
  logic [2:0] sched_state;
  logic [7:0] obs;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  magnetron_sched #(
    .CLK_HZ      (CLK_HZ),
    .WINDOW_S    (WINDOW_S),
    .FAN_RUNON_S (FAN_RUNON_S),
    .BEEP_COUNT  (BEEP_COUNT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cooking     (cooking),
    .paused      (paused),
    .porta       (porta),
    .potencia    (potencia),
    .done        (done),
    .magnetron   (magnetron),
    .turntable   (turntable),
    .lamp        (lamp),
    .fan         (fan),
    .buzzer      (buzzer),
    .sched_state (sched_state)
  );

  assign obs = {sched_state, magnetron, turntable, lamp, fan, buzzer};

  // Reference: mode 0 idle, 1 heat, 2 hold, 3 beep; time is counted in
  // running clock cycles since the last timebase restart.
  int m_mode, m_time, m_runon_secs;
  bit m_cook_prev;

  function automatic void model_reset();
    m_mode = 0; m_time = 0; m_runon_secs = 0; m_cook_prev = 1'b0;
  endfunction

  function automatic int duty_secs(input logic [1:0] p);
    case (p)
      2'd0: return 0;
      2'd1: return 3;
      2'd2: return 6;
      default: return WINDOW_S;
    endcase
  endfunction

  function automatic logic [7:0] model_out();
    logic [2:0] st;
    logic mg, tt, lp, fn, bz;
    st = 3'(m_mode);
    mg = (m_mode == 1) && (((m_time / SEC) % WINDOW_S) < duty_secs(potencia)) && !porta;
    tt = (m_mode == 1);
    lp = porta || (m_mode == 1) || (m_mode == 2);
    fn = (m_mode == 1) || (m_mode == 2) || (m_runon_secs > 0);
    bz = (m_mode == 3) && (((m_time / HALF) % 2) == 0);
    return {st, mg, tt, lp, fn, bz};
  endfunction

  function automatic void model_step();
    bit running, sec_edge, restart, start_runon, kill_runon;
    int later, nxt;
    running     = (m_mode == 1) || (m_mode == 3) || (m_runon_secs > 0);
    later       = running ? m_time + 1 : m_time;
    sec_edge    = running && ((later % SEC) == 0);
    nxt         = m_mode;
    restart     = 1'b0;
    start_runon = 1'b0;
    kill_runon  = 1'b0;
    if (m_mode == 0) begin
      if (done) begin nxt = 3; restart = 1'b1; end
      else if (cooking && !porta) begin nxt = 1; restart = 1'b1; kill_runon = 1'b1; end
    end else if (m_mode == 1 || m_mode == 2) begin
      if (done) begin nxt = 3; restart = 1'b1; start_runon = 1'b1; end
      else if (!cooking) begin nxt = 0; start_runon = 1'b1; end
      else if (m_mode == 1 && (porta || paused)) nxt = 2;
      else if (m_mode == 2 && !paused && !porta) nxt = 1;
    end else begin
      if (cooking && !m_cook_prev && !porta) begin nxt = 1; restart = 1'b1; kill_runon = 1'b1; end
      else if (later == BEEP_LEN) nxt = 0;
    end
    if (start_runon) m_runon_secs = FAN_RUNON_S;
    else if (kill_runon) m_runon_secs = 0;
    else if (sec_edge && m_runon_secs > 0) m_runon_secs = m_runon_secs - 1;
    m_time      = restart ? 0 : later;
    m_mode      = nxt;
    m_cook_prev = cooking;
  endfunction

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got {st,mag,tt,lamp,fan,buz}=%b required %b", nm, $time, got, exp);
    end
  endtask

  // One clock: DUT and model both see the current inputs at the rising edge.
  task automatic step_cycle();
    @(posedge clock);
    model_step();
    #1;
    done = 1'b0;
    @(negedge clock);
    check("model", obs, model_out());
  endtask

  typedef struct {
    logic       c, p, d;
    logic [1:0] pw;
    logic       dn;
    int         cyc;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic c, input logic p, input logic d, input logic [1:0] pw,
                     input logic dn, input int cyc, input logic [2:0] st, input logic mg,
                     input logic tt, input logic lp, input logic fn, input logic bz);
    vec_t v;
    v.c = c; v.p = p; v.d = d; v.pw = pw; v.dn = dn; v.cyc = cyc;
    v.exp = {st, mg, tt, lp, fn, bz};
    tbl.push_back(v);
  endtask

  initial begin
    // c  p  d  pw  dn  cyc   st mg tt lp fn bz
    add(0, 0, 0, 0, 0,   2,  0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0,   1,  1, 1, 1, 1, 1, 0);
    add(1, 0, 0, 1, 0,  59,  1, 1, 1, 1, 1, 0);
    add(1, 0, 0, 1, 0,   1,  1, 0, 1, 1, 1, 0);
    add(1, 0, 0, 1, 0, 140,  1, 1, 1, 1, 1, 0);
    add(1, 0, 0, 2, 0,  80,  1, 1, 1, 1, 1, 0);
    add(1, 0, 1, 2, 0,   0,  1, 0, 1, 1, 1, 0);
    add(1, 0, 1, 2, 0,   1,  2, 0, 0, 1, 1, 0);
    add(1, 0, 1, 2, 0,  30,  2, 0, 0, 1, 1, 0);
    add(1, 0, 0, 2, 0,   1,  1, 1, 1, 1, 1, 0);
    add(1, 0, 0, 2, 0,  38,  1, 1, 1, 1, 1, 0);
    add(1, 0, 0, 2, 0,   1,  1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 2, 1,   1,  3, 0, 0, 0, 1, 1);
    add(0, 0, 0, 2, 0,   9,  3, 0, 0, 0, 1, 1);
    add(0, 0, 0, 2, 0,   1,  3, 0, 0, 0, 1, 0);
    add(0, 0, 0, 2, 0,  49,  3, 0, 0, 0, 1, 0);
    add(0, 0, 0, 2, 0,   1,  0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 2, 0,  39,  0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 2, 0,   1,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 2, 0,  20,  0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 3, 0,   1,  1, 1, 1, 1, 1, 0);
    add(1, 0, 0, 3, 0, 100,  1, 1, 1, 1, 1, 0);
    add(1, 1, 1, 3, 1,   1,  3, 0, 0, 1, 1, 1);
    add(0, 0, 0, 3, 0,   5,  3, 0, 0, 0, 1, 1);
    add(1, 0, 0, 1, 0,   1,  1, 1, 1, 1, 1, 0);
    add(0, 0, 0, 1, 0,   1,  0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0,  98,  0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0,   1,  0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 2, 0,   1,  1, 1, 1, 1, 1, 0);
    add(1, 1, 0, 2, 0,   1,  2, 0, 0, 1, 1, 0);
    add(1, 1, 1, 2, 1,   1,  3, 0, 0, 1, 1, 1);
    add(0, 0, 0, 2, 0,  60,  0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0,   1,  1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0,   1,  0, 0, 0, 0, 1, 0);

    model_reset();
    #23;
    check("reset_state", obs, 8'b000_00000);
    @(negedge clock);
    reset = 1'b1;
    #1;

    foreach (tbl[i]) begin
      cooking = tbl[i].c; paused = tbl[i].p; porta = tbl[i].d;
      potencia = tbl[i].pw; done = tbl[i].dn;
      for (int k = 0; k < tbl[i].cyc; k++) step_cycle();
      #1;
      check($sformatf("vec%0d", i), obs, tbl[i].exp);
    end

    // Asynchronous reset in the middle of a heating cycle.
    cooking = 1'b1; potencia = 2'd2; porta = 1'b0; paused = 1'b0;
    repeat (25) step_cycle();
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", obs, 8'b000_00000);
    porta = 1'b1;
    #1;
    check("reset_lamp", obs, 8'b000_00100);
    @(posedge clock);
    #1;
    check("reset_hold", obs, 8'b000_00100);
    cooking = 1'b0;
    porta   = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    #1;
    check("post_reset", obs, 8'b000_00000);

    // Randomised run against the reference model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 29) == 0) cooking = ~cooking;
      if ($urandom_range(0, 19) == 0) paused = ~paused;
      if ($urandom_range(0, 24) == 0) porta = ~porta;
      if ($urandom_range(0, 39) == 0) potencia = 2'($urandom_range(0, 3));
      done = ($urandom_range(0, 119) == 0);
      step_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/magnetron_sched.md
Name: magnetron_sched

Overview:
- Sequences the physical loads of the microwave from the top-level cooking FSM status and the selected power level.
- Time-slices the magnetron inside a fixed duty window:
  - power 1 → 3 of 10 s on
  - power 2 → 6 of 10 s on
  - power 3 → 10 of 10 s on
- Also drives the turntable, cavity lamp, cooling fan (with run-on) and the end-of-cook buzzer pattern.
- Sits beside the countdown timer and is fed by the main control FSM; it never alters time or power values.

Parameters:
- CLK_HZ, 100_000_000, clock frequency; half-second prescale = CLK_HZ/2 cycles.
- WINDOW_S, 10, duty window length in seconds.
- FAN_RUNON_S, 5, seconds the fan keeps running after heating ends.
- BEEP_COUNT, 3, buzzer pulses after done; each pulse is 0.5 s on, 0.5 s off.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cooking  in  1  level, high while the main FSM is in the cooking or paused state.
- paused  in  1  level, main FSM paused.
- porta  in  1  door open (1 = open).
- potencia  in  2  power level 1..3; 0 means no heating.
- done  in  1  one-cycle pulse, countdown reached zero.
- magnetron  out  1  magnetron enable.
- turntable  out  1  turntable motor.
- lamp  out  1  cavity lamp.
- fan  out  1  cooling fan.
- buzzer  out  1  buzzer drive.
- sched_state  out  3  current state, for debug/LEDs.

Behaviour:
Reset:
- reset low asynchronously clears state to IDLE and zeroes prescaler, window counter, run-on counter and beep counter.
- All outputs are 0 during and after reset, except lamp = porta.

Tick generation:
- Prescaler produces tick_half every CLK_HZ/2 cycles.
- tick_sec is produced on every second tick_half.
- Prescaler runs only in HEAT, BEEP, or while the run-on counter is nonzero. It is frozen in HOLD and IDLE.

Duty window:
- win_cnt counts 0..WINDOW_S-1 on tick_sec in HEAT, wrapping to 0.
- on_secs comes from potencia: 0→0, 1→3, 2→6, 3→WINDOW_S.
- magnetron = (state==HEAT) & (win_cnt < on_secs) & ~porta.
- The porta gating is combinational, giving zero-latency interlock; all other terms are registered.
- potencia is sampled every cycle, so a change takes effect at the next evaluation.

States:
- IDLE: cooking & ~porta → HEAT; clears prescaler and win_cnt. done → BEEP.
- HEAT: transitions in priority order (highest first):
  - done → BEEP
  - ~cooking (stop) → IDLE
  - porta | paused → HOLD
- HOLD: win_cnt and prescaler frozen. Priority order:
  - done → BEEP
  - ~cooking → IDLE
  - cooking & ~paused & ~porta → HEAT, resuming at the frozen win_cnt.
- BEEP:
  - buzzer high during even half-periods; beep_cnt counts tick_half up to 2*BEEP_COUNT, then → IDLE.
  - A rising cooking with ~porta aborts the beep: → HEAT, win_cnt cleared.

Run-on:
- Leaving HEAT or HOLD to IDLE or BEEP loads runon_cnt = FAN_RUNON_S.
- runon_cnt decrements on tick_sec while nonzero; re-entering HEAT clears it.

Outputs:
- fan = (state==HEAT) | (state==HOLD) | (runon_cnt != 0).
- turntable = (state==HEAT).
- lamp = porta | (state==HEAT) | (state==HOLD).
- buzzer = 0 outside BEEP.

Other rules:
- done arriving simultaneously with porta, pause or stop: done wins.
- done in HOLD with porta open still goes to BEEP.
- Counter widths: $clog2 of their maxima; no overflow is possible by construction.

Decomposition:
- Shared package ctrl_microondas_pkg holds:
  - state encoding: IDLE=0, HEAT=1, HOLD=2, BEEP=3
  - the power→on_secs constants (3, 6, 10)
- One sub-module, tick_gen (prescaler with enable, clear, tick_half and tick_sec outputs), is natural.
- The FSM, window, run-on and beep logic stay in magnetron_sched.

Test Plan:
All scenarios use CLK_HZ=20, i.e. tick_half every 10 cycles and tick_sec every 20.
1. Reset low mid-HEAT: all outputs drop to 0 asynchronously; sched_state=0 after release; lamp follows porta.
2. potencia=1, cooking=1 held for 400 cycles: magnetron high for win_cnt 0..2, i.e. 60 of every 200 cycles; turntable and fan stay high.
3. In HEAT at win_cnt=4, potencia=2, assert porta: magnetron low the same cycle and state→HOLD. Close porta: HEAT resumes at win_cnt=4 and magnetron is high for 2 more seconds.
4. done pulse in HEAT: buzzer shows 3 pulses of 10 cycles high / 10 low, then IDLE after 60 cycles; fan stays high 100 cycles after leaving HEAT.
5. done, paused and porta asserted in the same cycle from HEAT: → BEEP, not HOLD.
6. New cooking rising during BEEP: buzzer low next cycle, state HEAT, win_cnt=0, runon cleared.
